ahb_slave_mem: RTL and testbench

AHB_SLAVE_MEM -- requirements
Module: ahb_slave_mem

---
 rtl/ahb_slave_mem.sv | 182 ++++++++++++++++++
 tb/tb_ahb_slave_mem.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory slave: 32-bit word-organised RAM with byte-lane writes,
// a configurable number of OKAY wait states and the two-cycle ERROR response
// for out-of-range, oversized or misaligned transfers.
module ahb_slave_mem #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 16384,
  parameter int          WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  // Word-index width; kept at least 1 so a single-word memory still elaborates.
  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // Size of the decoded window in bytes, wide enough that 4*DEPTH never wraps.
  localparam logic [33:0] MEM_BYTES = 34'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WS        = 4'(WAIT_STATES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR1 = 2'd2;
  localparam logic [1:0] S_ERR2 = 2'd3;

  // Control state
  logic [1:0]    r_state;
  logic [3:0]    r_cnt;
  logic          r_active;   // an OKAY transfer owns the current data phase
  logic          r_write;
  logic [3:0]    r_be;
  logic [AW-1:0] r_idx;

  // Address-phase decode
  logic [33:0]   w_off;
  logic          w_in_range;
  logic          w_size_ok;
  logic          w_aligned;
  logic          w_valid;
  logic          w_can_accept;
  logic          w_accept;
  logic [3:0]    w_be;
  logic [AW-1:0] w_idx;

  // Data-phase control
  logic          w_complete;
  logic          w_wr_en;
  logic [AW-1:0] w_rd_idx;
  logic [31:0]   w_rdata;

  // Offset is computed with two guard bits: an address below BASE_ADDR wraps
  // to a huge value and therefore fails the same upper-bound compare.
  assign w_off      = {2'b00, HADDR} - {2'b00, BASE_ADDR};
  assign w_in_range = (w_off < MEM_BYTES);
  assign w_idx      = w_off[AW+1:2];

  // Size legality, alignment and the byte lanes a transfer touches
  always_comb begin
    w_size_ok = 1'b1;
    w_aligned = 1'b1;
    w_be      = 4'b0000;
    case (HSIZE)
      3'b000: w_be = 4'b0001 << HADDR[1:0];
      3'b001: begin
        w_aligned = ~HADDR[0];
        w_be      = HADDR[1] ? 4'b1100 : 4'b0011;
      end
      3'b010: begin
        w_aligned = (HADDR[1:0] == 2'b00);
        w_be      = 4'b1111;
      end
      default: w_size_ok = 1'b0;
    endcase
  end

  assign w_valid = w_in_range & w_size_ok & w_aligned;

  // ERR2 behaves as IDLE, so a new address phase may be taken there too.
  // WAIT and ERR1 hold HREADYOUT low, so a well-formed bus never offers a
  // transfer to us in those states; ignoring it keeps the FSM safe anyway.
  assign w_can_accept = (r_state == S_IDLE) || (r_state == S_ERR2);
  assign w_accept     = HSEL && ((HTRANS == 2'b10) || (HTRANS == 2'b11)) &&
                        HREADY && w_can_accept;

  // The completing cycle of an OKAY transfer is an IDLE cycle with r_active.
  assign w_complete = (r_state == S_IDLE) && r_active;
  // Reset at the completing edge cancels the write along with the transfer.
  assign w_wr_en    = w_complete && r_write && !HRESET;

  // The RAM read is registered, so the address has to be presented one edge
  // before the completing cycle: the held index while waiting, or the fresh
  // address-phase index when a zero-wait transfer is being accepted.
  assign w_rd_idx = (r_state == S_WAIT) ? r_idx : w_idx;

  // Transfer FSM: acceptance, wait countdown and the two-cycle error response
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_active <= 1'b0;
      r_write  <= 1'b0;
      r_be     <= 4'b0000;
      r_idx    <= '0;
    end else begin
      case (r_state)
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= S_IDLE;
          end
        end
        S_ERR1: begin
          r_state <= S_ERR2;
        end
        default: begin
          r_active <= 1'b0;
          r_cnt    <= 4'd0;
          r_state  <= S_IDLE;
          if (w_accept) begin
            if (w_valid) begin
              r_active <= 1'b1;
              r_write  <= HWRITE;
              r_be     <= w_be;
              r_idx    <= w_idx;
              if (WS != 4'd0) begin
                r_state <= S_WAIT;
                r_cnt   <= WS;
              end
            end else begin
              r_state <= S_ERR1;
            end
          end
        end
      endcase
    end
  end

  // One byte-wide RAM per lane so each lane has its own simple write enable.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_mem [DEPTH_WORDS];
      logic [7:0] r_rd_byte;

      // Lane write, committed at the edge that ends the completing cycle
      always_ff @(posedge HCLK) begin
        if (w_wr_en && r_be[gi]) begin
          r_mem[r_idx] <= HWDATA[8*gi +: 8];
        end
      end

      // Registered lane read; a write landing on the same word at the same
      // edge is forwarded so a zero-wait read-after-write sees new data.
      always_ff @(posedge HCLK) begin
        if (w_wr_en && r_be[gi] && (r_idx == w_rd_idx)) begin
          r_rd_byte <= HWDATA[8*gi +: 8];
        end else begin
          r_rd_byte <= r_mem[w_rd_idx];
        end
      end

      assign w_rdata[8*gi +: 8] = r_rd_byte;
    end
  endgenerate

  // Bus outputs decoded from state; read data only shows in a read's
  // completing cycle and is zero otherwise (including error responses).
  always_comb begin
    HREADYOUT = !((r_state == S_WAIT) || (r_state == S_ERR1));
    HRESP     = (r_state == S_ERR1) || (r_state == S_ERR2);
    HRDATA    = (w_complete && !r_write) ? w_rdata : 32'h0000_0000;
  end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: two instances (zero and one wait state) share the
// bus; a byte-level memory model and a data-phase timing model predict every
// cycle's HREADYOUT/HRESP/HRDATA.
module tb_ahb_slave_mem;

  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam int          DEPTH  = 64;
  localparam int          NBYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel0, hsel1, hwrite, stall;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hready;
  logic        ro0, ro1, rs0, rs1;
  logic [31:0] rd0, rd1;
  int          cur;   // selected instance; equals its wait-state count

  always #5 clk = ~clk;

  // Bus-wide ready: the selected slave's ready, or forced low by another slave.
  assign hready = stall ? 1'b0 : ((cur == 1) ? ro1 : ro0);

  ahb_slave_mem #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_ws0 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(ro0), .HRESP(rs0), .HRDATA(rd0));

  ahb_slave_mem #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(1)) u_ws1 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel1), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(ro1), .HRESP(rs1), .HRDATA(rd1));

  typedef struct {
    logic        idle;     // IDLE/BUSY address phase, no data phase
    logic [1:0]  htrans;
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } xfer_t;

  typedef struct {
    logic [31:0] rdata;
    logic        resp;
  } res_t;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_resp;
  } vec_t;

  xfer_t       xq[$];
  res_t        rq[$];
  logic [7:0]  mdl [2][NBYTES];
  int          errors = 0;
  int          checks = 0;
  bit          quiet  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Reference rules for legality, byte writes and word reads.
  function automatic bit m_bad(input xfer_t x);
    if (!((x.addr >= BASE) && (x.addr < BASE + 32'(NBYTES)))) return 1'b1;
    if (x.size > 3'd2) return 1'b1;
    if ((x.size == 3'd1) && x.addr[0]) return 1'b1;
    if ((x.size == 3'd2) && (x.addr[1:0] != 2'b00)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void m_write(input int d, input xfer_t x);
    int nb  = 1 << x.size;
    int off = int'(x.addr - BASE);
    for (int k = 0; k < nb; k++) begin
      int lane = (off + k) % 4;
      mdl[d][off + k] = x.wdata[8*lane +: 8];
    end
  endfunction

  function automatic logic [31:0] m_read(input int d, input logic [31:0] addr);
    int off = (int'(addr - BASE) / 4) * 4;
    return {mdl[d][off+3], mdl[d][off+2], mdl[d][off+1], mdl[d][off]};
  endfunction

  function automatic xfer_t mk(input logic w, input logic [31:0] a,
                               input logic [2:0] s, input logic [31:0] wd);
    xfer_t x;
    x.idle = 1'b0; x.htrans = 2'b10; x.write = w; x.addr = a; x.size = s; x.wdata = wd;
    return x;
  endfunction

  task automatic set_sel(input logic s);
    hsel0 = (cur == 0) && s;
    hsel1 = (cur == 1) && s;
  endtask

  // Issues xq back to back on instance cur and checks every cycle against the
  // model: a good transfer's data phase lasts cur+1 cycles with ready only in
  // the last one, a bad one lasts two cycles (ready 0 then 1, resp high).
  task automatic run_xfers(output int ncyc);
    xfer_t       dp;
    bit          dv = 0, de = 0;
    int          dc = 0, idx = 0;
    logic        er, es, ar, as;
    logic [31:0] ed, ad;
    res_t        r;
    rq.delete();
    ncyc = 0;
    while (idx < xq.size() || dv) begin
      ncyc++;
      if (idx < xq.size()) begin
        set_sel(xq[idx].idle ? 1'($urandom_range(0, 1)) : 1'b1);
        htrans = xq[idx].htrans; hwrite = xq[idx].write;
        haddr  = xq[idx].addr;   hsize  = xq[idx].size;
      end else begin
        set_sel(1'b0);
        htrans = 2'b00; haddr = $urandom; hwrite = 1'($urandom); hsize = 3'($urandom);
      end
      hwdata = (dv && dp.write) ? dp.wdata : $urandom;
      if (!dv) begin
        er = 1'b1; es = 1'b0; ed = 32'h0;
      end else if (de) begin
        er = (dc == 1); es = 1'b1; ed = 32'h0;
      end else begin
        er = (dc == cur); es = 1'b0;
        ed = (er && !dp.write) ? m_read(cur, dp.addr) : 32'h0;
      end
      @(negedge clk);
      ar = (cur == 1) ? ro1 : ro0;
      as = (cur == 1) ? rs1 : rs0;
      ad = (cur == 1) ? rd1 : rd0;
      chkb($sformatf("hreadyout d%0d x%0d c%0d", cur, idx, ncyc), ar, er);
      chkb($sformatf("hresp d%0d x%0d c%0d", cur, idx, ncyc), as, es);
      chk($sformatf("hrdata d%0d x%0d c%0d", cur, idx, ncyc), ad, ed);
      chkb($sformatf("other_ready d%0d c%0d", cur, ncyc), (cur == 1) ? ro0 : ro1, 1'b1);
      if (dv && er) begin
        r.rdata = ad; r.resp = as;
        rq.push_back(r);
        if (!quiet)
          $display("xfer d%0d %s addr=%h size=%0d wdata=%h rdata=%h resp=%0d",
                   cur, dp.write ? "W" : "R", dp.addr, dp.size, dp.wdata, ad, as);
      end
      @(posedge clk); #1;
      if (dv) begin
        if (er) begin
          if (dp.write && !de) m_write(cur, dp);
          dv = 0;
        end else begin
          dc++;
        end
      end
      if (idx < xq.size() && er) begin
        if (!xq[idx].idle) begin
          dp = xq[idx]; dv = 1; dc = 0; de = m_bad(dp);
        end
        idx++;
      end
    end
    set_sel(1'b0);
    htrans = 2'b00;
  endtask

  vec_t        vt[18];
  int          n;
  logic [31:0] a, bdat [4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Directed table on the one-wait-state instance (memory zeroed first).
    vt[0]  = '{1'b1, BASE + 32'h13, 3'd0, 32'h5500_0000, 32'h0000_0000, 1'b0};
    vt[1]  = '{1'b0, BASE + 32'h10, 3'd2, 32'h0,         32'h5500_0000, 1'b0};
    vt[2]  = '{1'b1, BASE + 32'h10, 3'd2, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vt[3]  = '{1'b0, BASE + 32'h10, 3'd2, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vt[4]  = '{1'b0, BASE + 32'h02, 3'd2, 32'h0,         32'h0000_0000, 1'b1};
    vt[5]  = '{1'b0, BASE + 32'h00, 3'd2, 32'h0,         32'h0000_0000, 1'b0};
    vt[6]  = '{1'b1, BASE + 32'h06, 3'd1, 32'hABCD_0000, 32'h0000_0000, 1'b0};
    vt[7]  = '{1'b0, BASE + 32'h04, 3'd2, 32'h0,         32'hABCD_0000, 1'b0};
    vt[8]  = '{1'b0, BASE + 32'h01, 3'd1, 32'h0,         32'h0000_0000, 1'b1};
    vt[9]  = '{1'b0, BASE + 32'h08, 3'd3, 32'h0,         32'h0000_0000, 1'b1};
    vt[10] = '{1'b1, BASE - 32'h04, 3'd2, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vt[11] = '{1'b0, BASE + 32'(NBYTES), 3'd2, 32'h0,    32'h0000_0000, 1'b1};
    vt[12] = '{1'b1, BASE + 32'hFC, 3'd2, 32'h1234_5678, 32'h0000_0000, 1'b0};
    vt[13] = '{1'b0, BASE + 32'hFC, 3'd2, 32'h0,         32'h1234_5678, 1'b0};
    vt[14] = '{1'b1, BASE + 32'h12, 3'd0, 32'h00AA_0000, 32'h0000_0000, 1'b0};
    vt[15] = '{1'b0, BASE + 32'h11, 3'd0, 32'h0,         32'hDEAA_BEEF, 1'b0};
    vt[16] = '{1'b1, BASE + 32'h12, 3'd2, 32'hCAFE_F00D, 32'h0000_0000, 1'b1};
    vt[17] = '{1'b0, BASE + 32'h10, 3'd2, 32'h0,         32'hDEAA_BEEF, 1'b0};

    cur = 1; stall = 1'b0; rst = 1'b1;
    hsel0 = 1'b0; hsel1 = 1'b0; htrans = 2'b00; hwrite = 1'b0;
    haddr = 32'h0; hsize = 3'd0; hwdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chkb("reset ready ws0", ro0, 1'b1);
    chkb("reset resp ws0", rs0, 1'b0);
    chk("reset rdata ws0", rd0, 32'h0);
    chkb("reset ready ws1", ro1, 1'b1);
    chkb("reset resp ws1", rs1, 1'b0);
    chk("reset rdata ws1", rd1, 32'h0);
    @(posedge clk); #1;

    // Zero both memories so the model knows every byte.
    quiet = 1;
    for (int d = 0; d < 2; d++) begin
      cur = d;
      xq.delete();
      for (int w = 0; w < DEPTH; w++) xq.push_back(mk(1'b1, BASE + 32'(4*w), 3'd2, 32'h0));
      run_xfers(n);
    end
    quiet = 0;

    // Table-driven single transfers.
    cur = 1;
    for (int i = 0; i < 18; i++) begin
      xq.delete();
      xq.push_back(mk(vt[i].write, vt[i].addr, vt[i].size, vt[i].wdata));
      run_xfers(n);
      chk($sformatf("tbl%0d count", i), 32'(rq.size()), 32'd1);
      if (rq.size() > 0) begin
        chk($sformatf("tbl%0d rdata", i), rq[0].rdata, vt[i].exp_rdata);
        chkb($sformatf("tbl%0d resp", i), rq[0].resp, vt[i].exp_resp);
      end
    end

    // Next transfer taken in the ERR2 cycle: err(1) + ERR2/accept + wait + done.
    xq.delete();
    xq.push_back(mk(1'b0, BASE + 32'h02, 3'd2, 32'h0));
    xq.push_back(mk(1'b0, BASE + 32'h10, 3'd2, 32'h0));
    run_xfers(n);
    chk("err2 accept cycles", 32'(n), 32'd5);
    if (rq.size() == 2) chk("err2 accept rdata", rq[1].rdata, 32'hDEAA_BEEF);

    // Zero-wait burst: 4 writes, 4 reads, then write/read of one word back to back.
    cur = 0;
    xq.delete();
    for (int i = 0; i < 4; i++) begin
      bdat[i] = $urandom;
      xq.push_back(mk(1'b1, BASE + 32'h40 + 32'(4*i), 3'd2, bdat[i]));
    end
    for (int i = 0; i < 4; i++) xq.push_back(mk(1'b0, BASE + 32'h40 + 32'(4*i), 3'd2, 32'h0));
    run_xfers(n);
    chk("b2b cycles", 32'(n), 32'd9);
    for (int i = 0; i < 4; i++)
      if (rq.size() == 8) chk($sformatf("b2b rdata%0d", i), rq[4+i].rdata, bdat[i]);
    xq.delete();
    xq.push_back(mk(1'b1, BASE + 32'h50, 3'd2, 32'hA5A5_0F0F));
    xq.push_back(mk(1'b0, BASE + 32'h50, 3'd2, 32'h0));
    run_xfers(n);
    if (rq.size() == 2) chk("raw fwd rdata", rq[1].rdata, 32'hA5A5_0F0F);

    // Reset during the wait state of a write discards it.
    cur = 1;
    xq.delete();
    xq.push_back(mk(1'b1, BASE + 32'h20, 3'd2, 32'h1111_1111));
    run_xfers(n);
    set_sel(1'b1); htrans = 2'b10; hwrite = 1'b1; haddr = BASE + 32'h20; hsize = 3'd2;
    @(posedge clk); #1;
    set_sel(1'b0); htrans = 2'b00; hwdata = 32'h2222_2222;
    @(negedge clk);
    chkb("rst-in-wait ready", ro1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chkb("after rst ready", ro1, 1'b1);
    chkb("after rst resp", rs1, 1'b0);
    chk("after rst rdata", rd1, 32'h0);
    @(posedge clk); #1;
    $display("xfer d1 W addr=%h cut by reset", BASE + 32'h20);
    xq.delete();
    xq.push_back(mk(1'b0, BASE + 32'h20, 3'd2, 32'h0));
    run_xfers(n);
    if (rq.size() == 1) chk("rst-cut write kept old", rq[0].rdata, 32'h1111_1111);

    // Another slave stalls the bus: our address phase must be ignored.
    stall = 1'b1;
    set_sel(1'b1); htrans = 2'b10; hwrite = 1'b1; haddr = BASE + 32'h30; hsize = 3'd2;
    hwdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chkb($sformatf("stall ready%0d", i), ro1, 1'b1);
      chkb($sformatf("stall resp%0d", i), rs1, 1'b0);
      @(posedge clk); #1;
    end
    set_sel(1'b0); htrans = 2'b00; stall = 1'b0;
    @(negedge clk);
    chkb("post-stall ready", ro1, 1'b1);
    @(posedge clk); #1;
    $display("xfer d1 W addr=%h held during stall", BASE + 32'h30);
    xq.delete();
    xq.push_back(mk(1'b0, BASE + 32'h30, 3'd2, 32'h0));
    run_xfers(n);
    if (rq.size() == 1) chk("stall mem unchanged", rq[0].rdata, 32'h0);

    // Randomized pipelined traffic on both instances.
    for (int d = 0; d < 2; d++) begin
      cur = d;
      xq.delete();
      for (int i = 0; i < 80; i++) begin
        xfer_t x;
        int    rr;
        x.idle   = ($urandom_range(0, 99) < 15);
        x.htrans = x.idle ? 2'($urandom_range(0, 1)) : (($urandom_range(0, 1) == 1) ? 2'b11 : 2'b10);
        x.write  = 1'($urandom);
        x.size   = ($urandom_range(0, 99) < 5) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        x.wdata  = $urandom;
        rr = $urandom_range(0, 99);
        if (rr < 85) begin
          a = BASE + 32'($urandom_range(0, NBYTES - 1));
          if (($urandom_range(0, 99) < 80) && (x.size <= 3'd2))
            a = a & ~((32'd1 << x.size) - 32'd1);
        end else if (rr < 90) begin
          a = BASE - 32'd4;
        end else if (rr < 95) begin
          a = BASE + 32'(NBYTES);
        end else begin
          a = $urandom;
        end
        x.addr = a;
        xq.push_back(x);
      end
      run_xfers(n);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
